// File: rtl/pll_lock_monitor.sv
// Windowed phase-error statistics and hysteretic lock detector for the ADPLL.
// Optional loss-of-lock sticky flag (lol_sticky_o) is built when PLL_LOCK_STICKY_EN is defined.
module pll_lock_monitor #(
  parameter int ERR_WIDTH      = 8,
  parameter int WINDOW_LOG2    = 4,
  parameter int LOCK_THRESH    = 4,
  parameter int LOCK_WINDOWS   = 4,
  parameter int UNLOCK_WINDOWS = 2
) (
  input  logic                 fpga_clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [ERR_WIDTH-1:0] error_i,
  input  logic                 error_valid_i,
  output logic [ERR_WIDTH-1:0] avg_err_o,
  output logic [ERR_WIDTH-1:0] peak_err_o,
  output logic                 window_done_o,
  output logic [1:0]           state_o,
  output logic                 lock_o
`ifdef PLL_LOCK_STICKY_EN
  ,
  output logic                 lol_sticky_o
`endif
);

  localparam int AW = ERR_WIDTH + WINDOW_LOG2;
  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam int BW = $clog2(UNLOCK_WINDOWS + 1);
  localparam logic [ERR_WIDTH-1:0] MAX_ABS  = {1'b0, {(ERR_WIDTH-1){1'b1}}};
  localparam logic [ERR_WIDTH-1:0] MOST_NEG = {1'b1, {(ERR_WIDTH-1){1'b0}}};
  localparam logic [ERR_WIDTH-1:0] THRESH   = ERR_WIDTH'(LOCK_THRESH);

  typedef enum logic [1:0] {
    UNLOCKED  = 2'b00,
    ACQUIRING = 2'b01,
    LOCKED    = 2'b10,
    LOSING    = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          good_cnt_q, good_cnt_d;
  logic [BW-1:0]          bad_cnt_q, bad_cnt_d;
  logic [WINDOW_LOG2-1:0] cnt_q;
  logic signed [AW-1:0]   acc_q, acc_sum, err_ext;
  logic [ERR_WIDTH-1:0]   peak_q, peak_final, abs_err;
  logic                   accept, window_end, good_window;

  assign accept     = enable_i & error_valid_i;
  assign window_end = accept & (&cnt_q);

  // The most-negative code has no positive twin, so it saturates.
  always_comb begin
    abs_err = error_i;
    if (error_i == MOST_NEG) begin
      abs_err = MAX_ABS;
    end else if (error_i[ERR_WIDTH-1]) begin
      abs_err = -error_i;
    end
  end

  assign err_ext     = {{WINDOW_LOG2{error_i[ERR_WIDTH-1]}}, error_i};
  assign acc_sum     = acc_q + err_ext;
  assign peak_final  = (abs_err > peak_q) ? abs_err : peak_q;
  assign good_window = (peak_final <= THRESH);

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (window_end) begin
      case (state_q)
        UNLOCKED: begin
          if (good_window) begin
            if (LOCK_WINDOWS == 1) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
            end else begin
              state_d    = ACQUIRING;
              good_cnt_d = GW'(1);
            end
          end
        end
        ACQUIRING: begin
          if (!good_window) begin
            state_d    = UNLOCKED;
            good_cnt_d = '0;
          end else if (good_cnt_q + 1'b1 >= GW'(LOCK_WINDOWS)) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (!good_window) begin
            if (UNLOCK_WINDOWS == 1) begin
              state_d   = UNLOCKED;
              bad_cnt_d = '0;
            end else begin
              state_d   = LOSING;
              bad_cnt_d = BW'(1);
            end
          end
        end
        LOSING: begin
          if (good_window) begin
            state_d   = LOCKED;
            bad_cnt_d = '0;
          end else if (bad_cnt_q + 1'b1 >= BW'(UNLOCK_WINDOWS)) begin
            state_d   = UNLOCKED;
            bad_cnt_d = '0;
          end else begin
            bad_cnt_d = bad_cnt_q + 1'b1;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // The final sample is folded in combinationally so results land one cycle after it.
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      peak_q        <= '0;
      avg_err_o     <= '0;
      peak_err_o    <= '0;
      window_done_o <= 1'b0;
      state_q       <= UNLOCKED;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      lock_o        <= 1'b0;
    end else begin
      window_done_o <= 1'b0;
      if (accept) begin
        cnt_q <= cnt_q + 1'b1;
        if (&cnt_q) begin
          avg_err_o     <= acc_sum[AW-1:WINDOW_LOG2];
          peak_err_o    <= peak_final;
          window_done_o <= 1'b1;
          acc_q         <= '0;
          peak_q        <= '0;
        end else begin
          acc_q  <= acc_sum;
          peak_q <= peak_final;
        end
      end
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      lock_o     <= state_d[1];
    end
  end

  assign state_o = state_q;

`ifdef PLL_LOCK_STICKY_EN
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      lol_sticky_o <= 1'b0;
    end else if (window_end && state_q[1] && (state_d == UNLOCKED)) begin
      lol_sticky_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: directed test-plan steps plus randomized traffic
// against a sample-queue reference model; covers lol_sticky_o when PLL_LOCK_STICKY_EN is set.
module tb_pll_lock_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       vld;
  logic [7:0] err;
  logic [7:0] avg_err;
  logic [7:0] peak_err;
  logic       window_done;
  logic [1:0] state;
  logic       lock;
`ifdef PLL_LOCK_STICKY_EN
  logic       lol_sticky;
`endif

  always #5 clk = ~clk;

  pll_lock_monitor dut (
    .fpga_clk_i    (clk),
    .reset_i       (rst),
    .enable_i      (en),
    .error_i       (err),
    .error_valid_i (vld),
    .avg_err_o     (avg_err),
    .peak_err_o    (peak_err),
    .window_done_o (window_done),
    .state_o       (state),
    .lock_o        (lock)
`ifdef PLL_LOCK_STICKY_EN
    ,
    .lol_sticky_o  (lol_sticky)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: raw samples of the open window plus lock bookkeeping.
  int   win_q[$];
  int   good_run, bad_run;
  bit   locked, sticky;
  logic [7:0] exp_avg, exp_peak;
  logic [1:0] exp_state;
  logic       exp_done;

  task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    checkValue("avg", avg_err, exp_avg);
    checkValue("peak", peak_err, exp_peak);
    checkValue("done", {7'd0, window_done}, {7'd0, exp_done});
    checkValue("state", {6'd0, state}, {6'd0, exp_state});
    checkValue("lock", {7'd0, lock}, {7'd0, locked});
`ifdef PLL_LOCK_STICKY_EN
    checkValue("sticky", {7'd0, lol_sticky}, {7'd0, sticky});
`endif
  endtask

  task automatic modelReset();
    win_q.delete();
    good_run  = 0;
    bad_run   = 0;
    locked    = 0;
    sticky    = 0;
    exp_avg   = '0;
    exp_peak  = '0;
    exp_state = 2'b00;
    exp_done  = 1'b0;
  endtask

  task automatic closeWindow();
    int sum = 0;
    int pk = 0;
    int a;
    int avg;
    bit good;
    foreach (win_q[i]) begin
      sum += win_q[i];
      a = (win_q[i] < 0) ? -win_q[i] : win_q[i];
      if (a > 127) a = 127;
      if (a > pk) pk = a;
    end
    avg      = (sum >= 0) ? sum / 16 : -((-sum + 15) / 16);
    exp_avg  = 8'(avg);
    exp_peak = 8'(pk);
    exp_done = 1'b1;
    good     = (pk <= 4);
    if (!locked) begin
      if (good) begin
        good_run++;
        if (good_run >= 4) begin
          locked   = 1;
          good_run = 0;
        end
      end else begin
        good_run = 0;
      end
    end else begin
      if (!good) begin
        bad_run++;
        if (bad_run >= 2) begin
          locked  = 0;
          bad_run = 0;
          sticky  = 1;
        end
      end else begin
        bad_run = 0;
      end
    end
    exp_state = locked ? ((bad_run > 0) ? 2'b11 : 2'b10) : ((good_run > 0) ? 2'b01 : 2'b00);
    win_q.delete();
  endtask

  // One clock cycle: drive at a falling edge, let the rising edge act, check at the next falling edge.
  task automatic applyStimulus(input int val, input bit e, input bit v);
    en  = e;
    vld = v;
    err = 8'(val);
    @(negedge clk);
    exp_done = 1'b0;
    if (e && v) begin
      win_q.push_back(val);
      if (win_q.size() == 16) closeWindow();
    end
    checkOutput();
  endtask

  task automatic midCycleReset();
    #2 rst = 1'b1;
    #1 modelReset();
    checkOutput();
    en  = 1'b0;
    vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    vld = 1'b0;
    err = '0;
    modelReset();
    #1 checkOutput();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput();

    $display("[TB] acquire");
    for (int i = 0; i < 64; i++) applyStimulus(2, 1, 1);
    checkValue("acq_state", {6'd0, state}, 8'd2);
    checkValue("acq_lock", {7'd0, lock}, 8'd1);
    checkValue("acq_avg", avg_err, 8'd2);

    $display("[TB] alternating and floor");
    for (int i = 0; i < 16; i++) applyStimulus((i % 2 == 0) ? -3 : 3, 1, 1);
    checkValue("alt_avg", avg_err, 8'd0);
    checkValue("alt_peak", peak_err, 8'd3);
    for (int i = 0; i < 16; i++) applyStimulus((i == 15) ? 0 : -1, 1, 1);
    checkValue("floor_avg", avg_err, 8'hFF);

    $display("[TB] hysteresis");
    for (int i = 0; i < 16; i++) applyStimulus((i == 7) ? -5 : 0, 1, 1);
    checkValue("hys_state", {6'd0, state}, 8'd3);
    checkValue("hys_peak", peak_err, 8'd5);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 1);
    checkValue("hys_relock", {6'd0, state}, 8'd2);
    for (int i = 0; i < 32; i++) applyStimulus(6, 1, 1);
    checkValue("hys_unlock", {6'd0, state}, 8'd0);
    checkValue("hys_lock", {7'd0, lock}, 8'd0);

    $display("[TB] saturation");
    for (int i = 0; i < 16; i++) applyStimulus(-128, 1, 1);
    checkValue("sat_peak", peak_err, 8'd127);
    checkValue("sat_avg", avg_err, 8'h80);

    $display("[TB] enable gating");
    for (int i = 0; i < 8; i++) applyStimulus(i - 3, 1, 1);
    for (int i = 0; i < 20; i++) applyStimulus(100, 0, 1);
    for (int i = 8; i < 16; i++) applyStimulus(i - 3, 1, 1);
    checkValue("gate_avg", avg_err, 8'd4);
    checkValue("gate_peak", peak_err, 8'd12);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      int r;
      int val;
      r   = int'($urandom_range(0, 9));
      val = (r < 8) ? int'($urandom_range(0, 8)) - 4 : int'($urandom_range(0, 255)) - 128;
      applyStimulus(val, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0));
    end

    $display("[TB] reset mid-window");
    for (int i = 0; i < 5; i++) applyStimulus(9, 1, 1);
    midCycleReset();
    checkOutput();
    for (int i = 0; i < 16; i++) applyStimulus(-2, 1, 1);
    checkValue("post_rst_avg", avg_err, 8'hFE);
    checkValue("post_rst_state", {6'd0, state}, 8'd1);
    applyStimulus(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
